// File: rtl/deser_pkg.sv
// Shared types and defaults for the serial-to-parallel front end.
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser8_sync.sv
// Framed serial-to-parallel collector: assembles WIDTH bits into a word and
// strobes it out as d_out/d_en for an enabled register; flags aborted frames.
module deser8_sync
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             sync,
    output logic [WIDTH-1:0] d_out,
    output logic             d_en,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_dout;
    logic             r_den;
    logic             r_ferr;
    logic             r_busy;
    logic             w_done;
    logic             w_abort;

    // Seed clears the stale partial word so a restart never inherits old bits.
    always_comb begin
        if (MSB_FIRST) begin
            w_seed    = {{(WIDTH-1){1'b0}}, bit_in};
            w_shifted = {r_shift[WIDTH-2:0], bit_in};
        end else begin
            w_seed    = {bit_in, {(WIDTH-1){1'b0}}};
            w_shifted = {bit_in, r_shift[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        if (bit_vld) begin
            unique case (r_state)
                IDLE: begin
                    if (sync) begin
                        w_shift_nxt = w_seed;
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sync) begin
                        w_abort     = 1'b1;
                        w_shift_nxt = w_seed;
                        w_cnt_nxt   = CW'(1);
                    end else begin
                        w_shift_nxt = w_shifted;
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            w_done      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_den   <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_den   <= w_done;
            r_ferr  <= w_abort;
            r_busy  <= (w_state_nxt == SHIFT);
            if (w_done) begin
                r_dout <= w_shifted;
            end
        end
    end

    assign d_out     = r_dout;
    assign d_en      = r_den;
    assign busy      = r_busy;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_deser8_sync.sv
// Directed bench: two deserialiser instances (MSB- and LSB-first) on shared
// inputs, the MSB-first one feeding an 8-bit enabled register.
module tb_deser8_sync;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_vld;
    logic       sync;
    logic [7:0] d_out_m;
    logic       d_en_m;
    logic       busy_m;
    logic       ferr_m;
    logic [7:0] d_out_l;
    logic       d_en_l;
    logic       busy_l;
    logic       ferr_l;
    logic       reg_rst;
    logic [7:0] q;

    int checks;
    int errors;
    int cyc;

    deser8_sync #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .sync(sync),
        .d_out(d_out_m), .d_en(d_en_m), .busy(busy_m), .frame_err(ferr_m)
    );

    deser8_sync #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .sync(sync),
        .d_out(d_out_l), .d_en(d_en_l), .busy(busy_l), .frame_err(ferr_l)
    );

    // Stand-in for the existing 8-bit enabled register (active-high reset).
    assign reg_rst = ~rst_n;
    always_ff @(posedge clk or posedge reg_rst) begin
        if (reg_rst) q <= '0;
        else if (d_en_m) q <= d_out_m;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic vld, input logic s, input logic b);
        bit_vld = vld;
        sync    = s;
        bit_in  = b;
        @(posedge clk);
        #1;
        cyc++;
        bit_vld = 1'b0;
        sync    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_in  = 1'($urandom_range(0, 1));
            bit_vld = 1'($urandom_range(0, 1));
            sync    = 1'b0;
            @(posedge clk);
            #1;
        end
        checks++;
        if ({d_out_m, d_en_m, busy_m, ferr_m} !== 11'd0) begin
            errors++;
            $display("FAIL reset_m: got d_out=%h d_en=%b busy=%b ferr=%b want all 0",
                     d_out_m, d_en_m, busy_m, ferr_m);
        end
        checks++;
        if ({d_out_l, d_en_l, busy_l, ferr_l, q} !== 19'd0) begin
            errors++;
            $display("FAIL reset_l: got d_out=%h d_en=%b busy=%b ferr=%b q=%h want all 0",
                     d_out_l, d_en_l, busy_l, ferr_l, q);
        end
        bit_vld = 1'b0;
        sync    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] w;
        int         pulses;
        w = 8'hAB;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, w[7-i]);
            if (d_en_m) pulses++;
            checks++;
            if (d_en_m !== (i == 7)) begin
                errors++;
                $display("FAIL basic_den bit%0d: got %b want %b", i, d_en_m, i == 7);
            end
        end
        checks++;
        if (d_out_m !== 8'hAB) begin
            errors++;
            $display("FAIL basic_dout: got %h want ab", d_out_m);
        end
        checks++;
        if (busy_m !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after: got %b want 0", busy_m);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (d_en_m !== 1'b0 || q !== 8'hAB || pulses != 1) begin
            errors++;
            $display("FAIL basic_reg: got d_en=%b q=%h pulses=%0d want 0 ab 1", d_en_m, q, pulses);
        end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        int         pulses;
        w = 8'hAB;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    if (d_en_m) pulses++;
                    checks++;
                    if (busy_m !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_busy gap%0d: got %b want 1", g, busy_m);
                    end
                end
            end
            step(1'b1, i == 0, w[7-i]);
            if (d_en_m) pulses++;
        end
        step(1'b0, 1'b0, 1'b0);
        if (d_en_m) pulses++;
        checks++;
        if (d_out_m !== 8'hAB || pulses != 1) begin
            errors++;
            $display("FAIL gap_word: got d_out=%h pulses=%0d want ab 1", d_out_m, pulses);
        end
    endtask

    task automatic test_abort();
        logic [7:0] w;
        int         pulses;
        int         ferrs;
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
        w = 8'h5C;
        pulses = 0;
        ferrs = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, w[7-i]);
            if (d_en_m) pulses++;
            if (ferr_m) ferrs++;
            if (i == 0) begin
                checks++;
                if (ferr_m !== 1'b1 || busy_m !== 1'b1 || d_en_m !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_flag: got ferr=%b busy=%b d_en=%b want 1 1 0",
                             ferr_m, busy_m, d_en_m);
                end
            end
        end
        checks++;
        if (d_out_m !== 8'h5C || pulses != 1 || ferrs != 1) begin
            errors++;
            $display("FAIL abort_word: got d_out=%h pulses=%0d ferrs=%0d want 5c 1 1",
                     d_out_m, pulses, ferrs);
        end
        // Boundary: abort with WIDTH-1 bits already collected.
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 1'b1);
        w = 8'h3C;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, w[7-i]);
            if (d_en_m) pulses++;
            if (i == 0) begin
                checks++;
                if (ferr_m !== 1'b1 || d_en_m !== 1'b0) begin
                    errors++;
                    $display("FAIL abort7_flag: got ferr=%b d_en=%b want 1 0", ferr_m, d_en_m);
                end
            end
        end
        checks++;
        if (d_out_m !== 8'h3C || pulses != 1) begin
            errors++;
            $display("FAIL abort7_word: got d_out=%h pulses=%0d want 3c 1", d_out_m, pulses);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int          first_en;
        int          second_en;
        int          ferrs;
        w = 16'hAB5C;
        first_en = -1;
        second_en = -1;
        ferrs = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i == 0) || (i == 8), w[15-i]);
            if (ferr_m) ferrs++;
            if (d_en_m) begin
                if (first_en < 0) begin
                    first_en = i;
                    checks++;
                    if (d_out_m !== 8'hAB) begin
                        errors++;
                        $display("FAIL b2b_first: got %h want ab", d_out_m);
                    end
                end else begin
                    second_en = i;
                    checks++;
                    if (d_out_m !== 8'h5C) begin
                        errors++;
                        $display("FAIL b2b_second: got %h want 5c", d_out_m);
                    end
                end
            end
        end
        checks++;
        if (first_en != 7 || second_en != 15 || ferrs != 0) begin
            errors++;
            $display("FAIL b2b_timing: got en@%0d,%0d ferrs=%0d want 7,15 0",
                     first_en, second_en, ferrs);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_lsb();
        logic [7:0] w;
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (d_en_m !== 1'b0 || d_out_m !== 8'h00 || busy_m !== 1'b0 || ferr_m !== 1'b0 || q !== 8'h00) begin
            errors++;
            $display("FAIL midrst: got d_en=%b d_out=%h busy=%b ferr=%b q=%h want 0 00 0 0 00",
                     d_en_m, d_out_m, busy_m, ferr_m, q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (d_en_m !== 1'b0 || d_out_m !== 8'h00 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got d_en=%b d_out=%h busy=%b want 0 00 0",
                     d_en_m, d_out_m, busy_m);
        end
        w = 8'b1101_0101;
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, w[7-i]);
        checks++;
        if (d_en_l !== 1'b1 || d_out_l !== 8'hAB) begin
            errors++;
            $display("FAIL lsb_word: got d_en=%b d_out=%h want 1 ab", d_en_l, d_out_l);
        end
        checks++;
        if (d_out_m !== 8'hD5) begin
            errors++;
            $display("FAIL lsb_msbview: got %h want d5", d_out_m);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        bit_in  = 1'b0;
        bit_vld = 1'b0;
        sync    = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_abort();
        test_back_to_back();
        test_reset_mid_lsb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deser8_sync.md
# deser8_sync

Serial-to-parallel front end for the 8-bit enabled register stage. It collects a framed bit stream, one bit per qualified cycle, into a WIDTH-bit word. On each complete word it presents the word on `d_out` with a one-cycle `d_en` strobe, wired directly to the register's `d`/`en` inputs. It also flags aborted frames.

## Interface
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 places the first received bit in `d_out[WIDTH-1]`; 0 places it in `d_out[0]`.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  serial data; sampled only when `bit_vld`=1.
- `bit_vld`  in  1  qualifies `bit_in` for this cycle.
- `sync`  in  1  frame marker; meaningful only with `bit_vld`=1; marks `bit_in` as bit 0 of a new word.
- `d_out`  out  WIDTH  last completed word; feeds the register `d`.
- `d_en`  out  1  one-cycle strobe, high for exactly one cycle per completed word; feeds the register `en`.
- `busy`  out  1  high while a word is partially collected.
- `frame_err`  out  1  one-cycle pulse; a partial word was discarded by a new `sync`.

## Operation
- Reset (`rst_n`=0, asynchronous) clears all state:
  - `d_out`=0, `d_en`=0, `busy`=0, `frame_err`=0
  - state=IDLE, bit count=0, shift register=0
- FSM states: IDLE, SHIFT.
- IDLE:
  - `bit_vld`&`sync`: load the first bit, count=1, go to SHIFT.
  - `bit_vld` without `sync`: bit dropped, no flag, stay in IDLE.
- SHIFT, `bit_vld`&!`sync`: shift the bit in, count+1.
  - When this is bit WIDTH: `d_out` takes the assembled word, `d_en`=1 for one cycle, count=0, go to IDLE.
- SHIFT, `bit_vld`&`sync`: discard the partial word, `frame_err`=1 for one cycle.
  - Restart with this bit as bit 0 (count=1), stay in SHIFT.
  - This applies even when the partial word holds WIDTH-1 bits; no `d_en` is issued.
- SHIFT, `bit_vld`=0: hold all state. There is no timeout.
- `busy` is a registered decode of state==SHIFT.
- `d_out` changes only together with `d_en`; otherwise it holds the previous word indefinitely.
- Bit counter is `$clog2(WIDTH+1)` bits wide and never exceeds WIDTH.
- Reset asserted mid-word: partial word lost, no `d_en`, no `frame_err`.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Completion latency:
  - The WIDTH-th bit is sampled at edge k.
  - `d_out` and `d_en` are valid after edge k.
  - `d_en` falls after edge k+1.
- Back-to-back words: the FSM is in IDLE during the `d_en` cycle, so a `sync` bit in that same cycle starts the next word. Sustained rate is one word per WIDTH qualified cycles.
- `frame_err` is asserted after the edge that samples the offending `sync`, in the same cycle `busy` stays high.
- `d_en` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `deser_pkg`:
  - State enum: IDLE, SHIFT.
  - Default WIDTH constant.
- Single module with no sub-modules. Shift register, counter and FSM are small enough to stay inline.
- The bench instantiates `deser8_sync` feeding the existing 8-bit enabled register. The bench drives that register's reset from `rst_n` through an inverter.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random `bit_in`/`bit_vld` -> all outputs 0.
- Basic word: `sync`+bits 1,0,1,0,1,0,1,1 on 8 consecutive cycles, MSB_FIRST=1 -> after the 8th edge `d_out`=0xAB, `d_en` high exactly 1 cycle. Register `q`=0xAB one edge later.
- Gapped input: same 0xAB stream with `bit_vld`=0 for 3 cycles between bits 4 and 5 -> `d_out`=0xAB. `busy` stays high across the gap; `d_en` is a single pulse.
- Abort:
  - Send 5 bits of 0xFF.
  - Then `sync`+0x5C (0,1,0,1,1,1,0,0).
  - Expect `frame_err` one pulse at the `sync`, then `d_out`=0x5C and exactly one `d_en`.
- Back-to-back: 0xAB then 0x5C, the second `sync` coinciding with the first `d_en` -> two `d_en` pulses 8 cycles apart, `d_out` 0xAB then 0x5C, no `frame_err`.
- Reset mid-word plus LSB-first:
  - Pull `rst_n` low after 4 bits -> no `d_en` and `d_out`=0.
  - Rerun with MSB_FIRST=0 sending 1,1,0,1,0,1,0,1 -> `d_out`=0xAB.
